// File: rtl/weight_loader.sv
// Write-side loader for the 54-byte weight RAM.
// Streams a frame of weight bytes plus a trailing checksum into the RAM port.
module weight_loader #(
  parameter int DEPTH = 54,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          s_valid,
  input  logic [7:0]    s_data,
  output logic          s_ready,
  output logic          wen,
  output logic [AW-1:0] waddr,
  output logic [7:0]    din,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_DONE
  } state_e;

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_e state_q, state_d;

  logic [AW-1:0] cnt_q, cnt_d;
  logic [7:0]    sum_q, sum_d;
  logic          wen_q, wen_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [7:0]    din_q, din_d;
  logic          err_q, err_d;

  logic hs;
  logic ready_c;

  assign hs = s_valid & ready_c;

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LOAD;
      end
      S_LOAD: begin
        if (hs && cnt_q == LAST) state_d = S_CHECK;
      end
      S_CHECK: begin
        if (hs) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state-decoded outputs
  always_comb begin
    ready_c = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      S_IDLE:  ready_c = 1'b0;
      S_LOAD:  ready_c = 1'b1;
      S_CHECK: ready_c = 1'b1;
      S_DONE:  done    = 1'b1;
      default: ready_c = 1'b0;
    endcase
  end

  assign s_ready = ready_c;
  assign busy    = ready_c;

  // datapath next-state
  always_comb begin
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    wen_d   = 1'b0;
    waddr_d = waddr_q;
    din_d   = din_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_d = '0;
          sum_d = '0;
          err_d = 1'b0;
        end
      end
      S_LOAD: begin
        if (hs) begin
          wen_d   = 1'b1;
          waddr_d = cnt_q;
          din_d   = s_data;
          sum_d   = sum_q + s_data;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      S_CHECK: begin
        // checksum byte is compared only, never written
        if (hs) err_d = (s_data != sum_q);
      end
      S_DONE: begin
        wen_d = 1'b0;
      end
      default: wen_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      sum_q   <= '0;
      wen_q   <= 1'b0;
      waddr_q <= '0;
      din_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      din_q   <= din_d;
      err_q   <= err_d;
    end
  end

  assign wen   = wen_q;
  assign waddr = waddr_q;
  assign din   = din_q;
  assign err   = err_q;

endmodule
